// File: rtl/csi2tx_ahb_slave_mem.sv
// ---------------------------------------------------------------------------
// csi2tx_ahb_slave_mem
//
// AHB slave responder backed by a word-organised memory. One instance sits
// behind each slave select of the CSI2TX AHB bus model (slots 1-3). It answers
// transfers with OKAY (after WAIT_STATES wait cycles) or, when the optional
// error checking is compiled in, with a two-cycle ERROR response.
//
// Optional feature macro: CSI2TX_AHB_SLV_ERR_EN
//   defined   : an out-of-range address (haddr[31:MEM_AW+2] != 0) or an address
//               misaligned for hsize gets an ERROR response and writes nothing.
//   undefined : hresp is tied to OKAY, upper address bits are ignored (word
//               address wraps) and the low address bits are used as-is.
//
// Parameters:
//   MEM_AW       word-address width, depth = 2**MEM_AW 32-bit words
//   WAIT_STATES  hready_out low cycles in each OKAY data phase (0-15)
//
// Ports:
//   hclk, hresetn       bus clock (rising edge), async active-low reset
//   hsel, hready_in     slave select and muxed bus hready
//   htrans, hwrite      transfer type and direction
//   haddr, hsize        byte address and access size (byte/half/word)
//   hburst              burst type, accepted but unused
//   hwdata              write data, valid in the data phase
//   hready_out, hresp   this slave's ready and response to the response mux
//   hrdata              read data, zero outside a completing read data phase
// ---------------------------------------------------------------------------
module csi2tx_ahb_slave_mem #(
    parameter int MEM_AW      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic        hready_in,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [31:0] haddr,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [31:0] hwdata,
    output logic        hready_out,
    output logic [1:0]  hresp,
    output logic [31:0] hrdata
);

    localparam int DEPTH = 1 << MEM_AW;
    // Count value on the last low cycle; WAIT is unreachable when WAIT_STATES=0.
    localparam logic [3:0] WS_LAST = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t            state;
    logic [3:0]        wcnt;
    logic              pend;      // OKAY data phase outstanding
    logic              dp_write;
    logic [MEM_AW+1:0] dp_addr;
    logic [2:0]        dp_size;
    logic [1:0]        hresp_q;

    logic [31:0]       mem [DEPTH];

    logic              accept;
    logic              addr_err;
    logic              dp_done;
    logic [3:0]        be;
    logic [MEM_AW-1:0] waddr;

    // Address phases are only sampled while this slave is driving ready high.
    assign accept = hsel & hready_in & htrans[1] & hready_out;

`ifdef CSI2TX_AHB_SLV_ERR_EN
    logic misalign;

    always_comb begin
        misalign = 1'b0;
        case (hsize)
            3'b000:  misalign = 1'b0;
            3'b001:  misalign = haddr[0];
            default: misalign = |haddr[1:0];
        endcase
    end

    assign addr_err = (|haddr[31:MEM_AW+2]) | misalign;
    assign hresp    = hresp_q;
`else
    logic unused_hi;
    logic unused_resp;

    assign addr_err    = 1'b0;
    assign hresp       = RESP_OKAY;
    assign unused_hi   = ^haddr[31:MEM_AW+2];
    assign unused_resp = ^hresp_q;
`endif

    logic unused_burst;
    assign unused_burst = ^hburst;

    // -----------------------------------------------------------------------
    // Transfer FSM. IDLE with pend set is the final (ready-high) cycle of an
    // OKAY data phase; IDLE and ERR2 both sample the next address phase.
    // -----------------------------------------------------------------------
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state      <= S_IDLE;
            wcnt       <= '0;
            pend       <= 1'b0;
            hready_out <= 1'b1;
            hresp_q    <= RESP_OKAY;
            dp_write   <= 1'b0;
            dp_addr    <= '0;
            dp_size    <= '0;
        end else begin
            case (state)
                S_WAIT: begin
                    wcnt <= wcnt + 4'd1;
                    if (wcnt == WS_LAST) begin
                        state      <= S_IDLE;
                        hready_out <= 1'b1;
                    end
                end
                S_ERR1: begin
                    // Second ERROR cycle raises ready with hresp still ERROR.
                    state      <= S_ERR2;
                    hready_out <= 1'b1;
                end
                default: begin
                    state      <= S_IDLE;
                    pend       <= 1'b0;
                    hready_out <= 1'b1;
                    hresp_q    <= RESP_OKAY;
                    if (accept) begin
                        dp_write <= hwrite;
                        dp_addr  <= haddr[MEM_AW+1:0];
                        dp_size  <= hsize;
                        if (addr_err) begin
                            state      <= S_ERR1;
                            hready_out <= 1'b0;
                            hresp_q    <= RESP_ERROR;
                        end else begin
                            pend <= 1'b1;
                            if (WAIT_STATES > 0) begin
                                state      <= S_WAIT;
                                hready_out <= 1'b0;
                                wcnt       <= '0;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Final cycle of an OKAY data phase.
    assign dp_done = pend & (state == S_IDLE);
    assign waddr   = dp_addr[MEM_AW+1:2];

    // Little-endian byte lanes; sizes above word behave as word.
    always_comb begin
        be = 4'b1111;
        case (dp_size)
            3'b000:  be = 4'b0001 << dp_addr[1:0];
            3'b001:  be = dp_addr[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // Memory is not reset; a write in flight at reset is lost because pend
    // clears asynchronously.
    always_ff @(posedge hclk) begin
        if (dp_done && dp_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[waddr][8*i +: 8] <= hwdata[8*i +: 8];
            end
        end
    end

    // Combinational read so a read directly after a write to the same word
    // sees the value committed on the edge that ended the write.
    assign hrdata = (dp_done && !dp_write) ? mem[waddr] : 32'h0;

endmodule

// File: tb/tb_csi2tx_ahb_slave_mem.sv
// ---------------------------------------------------------------------------
// Bench for csi2tx_ahb_slave_mem: two instances (0 and 3 wait states), each
// with its own driver, reference memory and scoreboard monitor.
// ---------------------------------------------------------------------------
module tb_csi2tx_ahb_slave_mem;

    localparam int MEM_AW = 8;

    typedef struct packed {
        logic        err;
        logic        rd;
        logic [31:0] rdata;
    } exp_t;

    logic hclk = 1'b0;
    always #5 hclk = ~hclk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got rdy=%b resp=%b rdata=%h, want rdy=%b resp=%b rdata=%h",
                     name, $time, act[34], act[33:32], act[31:0], exp[34], exp[33:32], exp[31:0]);
        end
    endtask

    // Reference rules: which accepted transfers get an ERROR response.
    function automatic bit ref_err(input logic [31:0] a, input logic [2:0] sz);
`ifdef CSI2TX_AHB_SLV_ERR_EN
        if ((a >> (MEM_AW + 2)) != 0) return 1'b1;
        if (sz == 3'd1) return a[0];
        if (sz >= 3'd2) return a[1:0] != 2'b00;
        return 1'b0;
`else
        return (a == 32'hFFFF_FFFF) && (sz == 3'd7) && 1'b0;
`endif
    endfunction

    // Reference write merge: size in bytes, lanes aligned down to the size.
    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [31:0] a, input logic [2:0] sz);
        logic [31:0] r;
        int nb, first;
        r     = old;
        nb    = (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
        first = (int'(a % 4) / nb) * nb;
        for (int b = first; b < first + nb; b++) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int WS = (g == 0) ? 0 : 3;

        logic        hresetn, hsel, hready_in, hwrite, hready_out;
        logic [1:0]  htrans, hresp;
        logic [2:0]  hsize, hburst;
        logic [31:0] haddr, hwdata, hrdata;

        logic [31:0] mdl [1 << MEM_AW];
        exp_t        q[$];
        exp_t        cur;
        bit          in_dp = 1'b0;
        int          cyc   = 0;
        bit          fin   = 1'b0;

        csi2tx_ahb_slave_mem #(.MEM_AW(MEM_AW), .WAIT_STATES(WS)) u_dut (
            .hclk      (hclk),
            .hresetn   (hresetn),
            .hsel      (hsel),
            .hready_in (hready_in),
            .htrans    (htrans),
            .hwrite    (hwrite),
            .haddr     (haddr),
            .hsize     (hsize),
            .hburst    (hburst),
            .hwdata    (hwdata),
            .hready_out(hready_out),
            .hresp     (hresp),
            .hrdata    (hrdata)
        );

        // Monitor: checks every cycle's response, pops an expectation on each
        // address phase the bus protocol says is accepted.
        always @(negedge hclk) begin
            logic [34:0] e;
            string nm;
            e  = {1'b1, 2'b00, 32'h0};
            nm = "idle";
            if (!hresetn) begin
                check("reset", {hready_out, hresp, hrdata}, e);
                in_dp = 1'b0;
            end else begin
                if (in_dp) begin
                    if (cur.err) begin
                        nm = "err_dphase";
                        e  = {(cyc != 0), 2'b01, 32'h0};
                        if (cyc != 0) in_dp = 1'b0;
                    end else if (cyc < WS) begin
                        nm = "wait_cycle";
                        e  = {1'b0, 2'b00, 32'h0};
                    end else begin
                        nm    = cur.rd ? "read_dphase" : "write_dphase";
                        e     = {1'b1, 2'b00, (cur.rd ? cur.rdata : 32'h0)};
                        in_dp = 1'b0;
                    end
                    cyc++;
                end
                check(nm, {hready_out, hresp, hrdata}, e);
                if (hsel && hready_in && htrans[1] && hready_out) begin
                    if (q.size() == 0) begin
                        miscompares++;
                        $display("FAIL accept_without_stimulus @%0t: got accept, want none", $time);
                    end else begin
                        cur   = q.pop_front();
                        in_dp = 1'b1;
                        cyc   = 0;
                    end
                end
            end
        end

        task automatic junk();
            hsel      = 1'($urandom);
            htrans    = 2'($urandom);
            hready_in = 1'($urandom);
            hwrite    = 1'($urandom);
            haddr     = $urandom;
            hsize     = 3'($urandom);
            hburst    = 3'($urandom);
        endtask

        // Called at posedge+1. Waits for ready, presents one address phase,
        // records the expected response and updates the reference memory.
        task automatic xfer(input bit sel, input logic [1:0] tr, input bit rdy, input bit wr,
                            input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd,
                            input bit abort);
            int guard;
            bit acc;
            guard = 0;
            while (hready_out !== 1'b1) begin
                junk();
                @(posedge hclk); #1;
                guard++;
                if (guard > 50) begin
                    miscompares++;
                    $display("FAIL ready_timeout inst%0d: got hready_out=%b for 50 cycles, want 1", g, hready_out);
                    return;
                end
            end
            hsel = sel; htrans = tr; hready_in = rdy; hwrite = wr;
            haddr = a; hsize = sz; hburst = 3'($urandom);
            acc = sel && rdy && tr[1];
            if (acc) begin
                exp_t e;
                int idx;
                idx     = int'((a >> 2) % (1 << MEM_AW));
                e.err   = ref_err(a, sz);
                e.rd    = !wr;
                e.rdata = 32'h0;
                if (!e.err) begin
                    if (wr) begin
                        if (!abort) mdl[idx] = ref_merge(mdl[idx], wd, a, sz);
                    end else begin
                        e.rdata = mdl[idx];
                    end
                end
                q.push_back(e);
            end
            @(posedge hclk); #1;
            hwdata = (acc && wr) ? wd : $urandom;
        endtask

        initial begin
            hresetn = 1'b0; hsel = 1'b0; htrans = 2'b00; hready_in = 1'b1; hwrite = 1'b0;
            haddr = '0; hsize = '0; hburst = '0; hwdata = '0;
            repeat (3) @(posedge hclk);
            #1 hresetn = 1'b1;
            xfer(0, 2'b00, 1, 0, 32'h0, 3'd2, 32'h0, 0);

            for (int i = 0; i < 16; i++) xfer(1, 2'b10, 1, 1, 32'(i * 4), 3'd2, $urandom, 0);

            // Word write, back-to-back read; byte and halfword merges.
            xfer(1, 2'b10, 1, 1, 32'h10, 3'd2, 32'hDEADBEEF, 0);
            xfer(1, 2'b10, 1, 0, 32'h10, 3'd2, 32'h0, 0);
            xfer(1, 2'b10, 1, 1, 32'h10, 3'd2, 32'h11223344, 0);
            xfer(1, 2'b11, 1, 1, 32'h13, 3'd0, 32'hAA5A5A5A, 0);
            xfer(1, 2'b11, 1, 0, 32'h10, 3'd2, 32'h0, 0);
            xfer(1, 2'b10, 1, 1, 32'h10, 3'd1, 32'h77775566, 0);
            xfer(1, 2'b11, 1, 0, 32'h10, 3'd2, 32'h0, 0);

            // Out-of-range write: ERROR (feature on) or alias of word 0 (off).
            xfer(1, 2'b10, 1, 1, 32'h400, 3'd2, 32'hCAFEF00D, 0);
            xfer(1, 2'b10, 1, 0, 32'h000, 3'd2, 32'h0, 0);

            // Reset in the middle of a write's wait states drops the write.
            if (WS > 0) begin
                xfer(1, 2'b10, 1, 1, 32'h20, 3'd2, 32'h0BADF00D, 1);
                @(posedge hclk); #1;
                hresetn = 1'b0; hsel = 1'b0;
                @(posedge hclk); #1;
                hresetn = 1'b1;
                xfer(1, 2'b10, 1, 0, 32'h20, 3'd2, 32'h0, 0);
            end

            for (int n = 0; n < 250; n++) begin
                logic [31:0] a;
                logic [2:0] sz;
                int r;
                sz = 3'($urandom_range(0, 3));
                a  = 32'($urandom_range(0, 63));
                r  = $urandom_range(0, 9);
                if (r < 7) begin
                    if (sz == 3'd1) a[0] = 1'b0;
                    if (sz >= 3'd2) a[1:0] = 2'b00;
                end
                if (r == 9) a = a | (32'h1 << $urandom_range(10, 31));
                xfer($urandom_range(0, 7) != 0, 2'($urandom), $urandom_range(0, 7) != 0,
                     1'($urandom), a, sz, $urandom, 0);
            end

            repeat (4) xfer(0, 2'b00, 1, 0, 32'h0, 3'd2, 32'h0, 0);
            fin = 1'b1;
        end
    end

    initial begin
        fork
            wait (gi[0].fin && gi[1].fin);
            #3_000_000;
        join_any
        disable fork;
        if (!(gi[0].fin && gi[1].fin)) begin
            miscompares++;
            $display("FAIL run_timeout: got drivers unfinished, want finished");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
